daisy_band_cal: RTL and testbench

- Automatic sub-band (coarse-tune) calibration FSM directly upstream of the VCO; it drives the VCO's 5-bit sub-range select D.
- While calibration runs, it asks the loop filter to park the VCO control at mid-scale (0.5).
- It counts edges of the divided, clk-synchronised VCO output over a fixed reference window, then binary-searches D against a target count.
- D=31 is the lowest-frequency sub-range and D=0 the highest, so a larger D means lower frequency.

---
 rtl/daisy_band_cal.sv | 148 ++++++++++++++
 tb/tb_daisy_band_cal.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/daisy_band_cal.sv
// daisy_band_cal: automatic sub-band (coarse-tune) calibration for the VCO.
//
// Parks the loop filter at mid-scale, then binary-searches the 5-bit VCO
// sub-range select.  For each trial D it waits SETTLE_CYC cycles, counts
// rising edges of the divided VCO over WIN_CYC cycles, and keeps the bit under
// test when the count exceeds the target (VCO too fast -> move to a larger,
// lower-frequency D).
//
// Ports:
//   clk       reference clock, rising edge
//   reset     synchronous active-high reset
//   start     one-cycle calibration request (accepted in IDLE/DONE only)
//   abort     return to IDLE immediately (wins over start)
//   target    desired edges per window, latched on the accepted start
//   vco_div   divided VCO, already synchronised to clk
//   d_out     sub-range select to the VCO (31 = lowest frequency)
//   hold_mid  forces the loop-filter output to mid-scale while high
//   busy      calibration in progress
//   done      calibration complete (level)
//   cnt_last  edge count of the most recent window
module daisy_band_cal #(
    parameter int         CNT_W      = 16,
    parameter int         SETTLE_CYC = 64,
    parameter int         WIN_CYC    = 256,
    parameter logic [4:0] D_RESET    = 5'd16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] target,
    input  logic             vco_div,
    output logic [4:0]       d_out,
    output logic             hold_mid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt_last
);

    localparam int TMR_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        DECIDE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [2:0]        idx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  target_q;
    logic              vco_div_q;
    logic              edge_seen;
    logic [4:0]        d_decided;

    // Counter saturates at all-ones so a very fast VCO never reads as slow.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        else
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign edge_seen = vco_div & ~vco_div_q;

    // Resolve the bit under test and pre-set the next one for the following trial.
    always_comb begin
        d_decided      = d_out;
        d_decided[idx] = (cnt > target_q);
        if (idx != 3'd0)
            d_decided[idx - 3'd1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            d_out     <= D_RESET;
            hold_mid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt_last  <= '0;
            vco_div_q <= 1'b0;
            tmr       <= '0;
            idx       <= 3'd0;
        end else begin
            vco_div_q <= vco_div;
            if (abort && state != IDLE) begin
                state    <= IDLE;
                d_out    <= D_RESET;
                busy     <= 1'b0;
                done     <= 1'b0;
                hold_mid <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start && !abort) begin
                            state    <= SETTLE;
                            idx      <= 3'd4;
                            d_out    <= 5'b10000;
                            busy     <= 1'b1;
                            hold_mid <= 1'b1;
                            done     <= 1'b0;
                            target_q <= target;
                            tmr      <= '0;
                        end
                    end
                    SETTLE: begin
                        if (tmr == TMR_W'(SETTLE_CYC - 1)) begin
                            state <= MEASURE;
                            tmr   <= '0;
                            cnt   <= '0;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (edge_seen)
                            cnt <= sat_inc(cnt);
                        if (tmr == TMR_W'(WIN_CYC - 1))
                            state <= DECIDE;
                        else
                            tmr <= tmr + TMR_W'(1);
                    end
                    DECIDE: begin
                        cnt_last <= cnt;
                        d_out    <= d_decided;
                        if (idx == 3'd0) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            hold_mid <= 1'b0;
                        end else begin
                            idx   <= idx - 3'd1;
                            state <= SETTLE;
                            tmr   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_daisy_band_cal.sv
module tb_daisy_band_cal;

    localparam int S = 4;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset, start, abort, vco_div;
    logic [15:0] target;
    logic [2:0]  target3;
    logic [4:0]  d_out, d_out2;
    logic        hold_mid, busy, done, hold_mid2, busy2, done2;
    logic [15:0] cnt_last;
    logic [2:0]  cnt_last2;

    int checks = 0;
    int errors = 0;

    logic [4:0]  exp_seq [5];
    logic [4:0]  exp_final;
    logic [15:0] exp_cnt;

    daisy_band_cal #(.CNT_W(16), .SETTLE_CYC(S), .WIN_CYC(W), .D_RESET(5'd16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
        .vco_div(vco_div), .d_out(d_out), .hold_mid(hold_mid), .busy(busy),
        .done(done), .cnt_last(cnt_last));

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    daisy_band_cal #(.CNT_W(3), .SETTLE_CYC(S), .WIN_CYC(W), .D_RESET(5'd16)) dut3 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target3),
        .vco_div(vco_div), .d_out(d_out2), .hold_mid(hold_mid2), .busy(busy2),
        .done(done2), .cnt_last(cnt_last2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // VCO plant: edges per window as a function of D (scaled to fit a 32-cycle
    // window, at most 16 edges).  mode 0: clamp(30-D,0,16); 1: none; 2: 16.
    function automatic int vco_edges(input int mode, input logic [4:0] d);
        int n;
        if (mode == 1) return 0;
        if (mode == 2) return 16;
        n = 30 - int'(d);
        if (n > 16) n = 16;
        if (n < 0) n = 0;
        return n;
    endfunction

    // One trial: SETTLE, WIN-cycle window with n edges, DECIDE.
    // phase 0 puts edges on odd window cycles (last cycle used), phase 1 on even
    // cycles (first cycle used).
    task automatic trial(input int mode, input int phase, input bit inject);
        int n;
        logic [4:0] d0;
        d0 = d_out;
        n = vco_edges(mode, d0);
        vco_div = 1'b0;
        repeat (S) tick();
        for (int c = 0; c < W; c++) begin
            if (phase == 0) vco_div = ((c % 2) == 1) && ((c / 2) < n);
            else            vco_div = ((c % 2) == 0) && ((c / 2) < n);
            start = inject && (c == 2);
            tick();
        end
        start = 1'b0;
        vco_div = 1'b0;
        checks++; if (d_out !== d0) begin errors++; $display("FAIL d_stable_in_window: got %0d expected %0d", d_out, d0); end
        checks++; if ({busy, hold_mid, done} !== 3'b110) begin errors++; $display("FAIL flags_before_decide: got %b expected 110", {busy, hold_mid, done}); end
        tick();
    endtask

    task automatic run_cal(input int mode, input int phase, input bit inject);
        target = 16'd15;
        target3 = 3'd1;
        if (mode != 0) target = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({busy, hold_mid, done} !== 3'b110) begin errors++; $display("FAIL start_accept_flags: got %b expected 110", {busy, hold_mid, done}); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (d_out !== exp_seq[k]) begin errors++; $display("FAIL trial_d[%0d]: got %0d expected %0d", k, d_out, exp_seq[k]); end
            trial(mode, phase, (k == 0) ? inject : 1'b0);
        end
        checks++; if ({busy, hold_mid, done} !== 3'b001) begin errors++; $display("FAIL done_flags: got %b expected 001", {busy, hold_mid, done}); end
        checks++; if (d_out !== exp_final) begin errors++; $display("FAIL final_d: got %0d expected %0d", d_out, exp_final); end
        checks++; if (cnt_last !== exp_cnt) begin errors++; $display("FAIL cnt_last: got %0d expected %0d", cnt_last, exp_cnt); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            abort = 1'($urandom);
            vco_div = 1'($urandom);
            target = 16'($urandom);
            target3 = 3'($urandom);
            tick();
        end
        checks++; if (d_out !== 5'd16) begin errors++; $display("FAIL reset_d: got %0d expected 16", d_out); end
        checks++; if ({busy, hold_mid, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, hold_mid, done}); end
        checks++; if (cnt_last !== 16'd0) begin errors++; $display("FAIL reset_cnt_last: got %0d expected 0", cnt_last); end
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        vco_div = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_during_reset: busy got %b expected 0", busy); end
    endtask

    task automatic test_nominal();
        exp_seq = '{5'd16, 5'd8, 5'd12, 5'd14, 5'd15};
        exp_final = 5'd14;
        exp_cnt = 16'd15;
        run_cal(0, 0, 1'b0);
    endtask

    task automatic test_endpoints();
        exp_seq = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};
        exp_final = 5'd0;
        exp_cnt = 16'd0;
        run_cal(1, 0, 1'b0);
        exp_seq = '{5'd16, 5'd24, 5'd28, 5'd30, 5'd31};
        exp_final = 5'd31;
        exp_cnt = 16'd16;
        run_cal(2, 1, 1'b0);
        checks++; if (d_out2 !== 5'd31) begin errors++; $display("FAIL sat_final_d: got %0d expected 31", d_out2); end
        checks++; if (cnt_last2 !== 3'd7) begin errors++; $display("FAIL sat_cnt_last: got %0d expected 7", cnt_last2); end
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL sat_done: got %b expected 1", done2); end
    endtask

    task automatic test_handshake();
        exp_seq = '{5'd16, 5'd8, 5'd12, 5'd14, 5'd15};
        exp_final = 5'd14;
        exp_cnt = 16'd15;
        run_cal(0, 0, 1'b1);
        target = 16'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (d_out !== 5'd16) begin errors++; $display("FAIL restart_d: got %0d expected 16", d_out); end
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL restart_flags: got %b expected 10", {busy, done}); end
    endtask

    task automatic test_abort();
        trial(0, 0, 1'b0);
        tick();
        tick();
        checks++; if (d_out !== 5'd8) begin errors++; $display("FAIL second_settle_d: got %0d expected 8", d_out); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (d_out !== 5'd16) begin errors++; $display("FAIL abort_d: got %0d expected 16", d_out); end
        checks++; if ({busy, hold_mid, done} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b expected 000", {busy, hold_mid, done}); end
        checks++; if (cnt_last !== 16'd14) begin errors++; $display("FAIL abort_cnt_kept: got %0d expected 14", cnt_last); end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++; if ({busy, hold_mid} !== 2'b00) begin errors++; $display("FAIL start_abort_idle: got %b expected 00", {busy, hold_mid}); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle_late: busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_measure();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (S + 3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_measure: got %b expected 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({busy, hold_mid, done} !== 3'b000) begin errors++; $display("FAIL reset_mid_flags: got %b expected 000", {busy, hold_mid, done}); end
        checks++; if (cnt_last !== 16'd0) begin errors++; $display("FAIL reset_mid_cnt_last: got %0d expected 0", cnt_last); end
        checks++; if (d_out !== 5'd16) begin errors++; $display("FAIL reset_mid_d: got %0d expected 16", d_out); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_idle: busy got %b expected 0", busy); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        vco_div = 1'b0;
        target = '0;
        target3 = '0;
        test_reset();
        test_nominal();
        test_endpoints();
        test_handshake();
        test_abort();
        test_reset_measure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
